// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, FSM state encodings and the
// parity helper. Used by both the transmitter and the receiver so the two
// ends always agree on framing.
package uart_pkg;

  // Frame constants
  localparam int unsigned DATA_BITS   = 8;
  localparam logic        IDLE_LEVEL  = 1'b1;
  localparam logic        START_LEVEL = 1'b0;
  localparam logic        STOP_LEVEL  = 1'b1;

  // Data-bit index: 0..DATA_BITS-1, never wraps within a frame
  localparam int unsigned           BIT_IDX_W    = 3;
  localparam logic [BIT_IDX_W-1:0]  FIRST_BIT_IDX = 3'd0;
  localparam logic [BIT_IDX_W-1:0]  LAST_BIT_IDX  = 3'd7;

  // Bit-period counter width (covers CLKS_PER_BIT up to 65535)
  localparam int unsigned BAUD_CNT_W = 16;

  // FSM state encodings
  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

  // Even parity: the bit that makes the total count of ones even
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer. A down-counter reloaded with CLKS_PER_BIT-1 on every
// bit boundary; 'tick' marks the last cycle of the current bit period.
// 'load' restarts the period (used on frame acceptance), 'run' lets the
// counter advance while a frame is on the line.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk_in,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic tick
);

  localparam logic [BAUD_CNT_W-1:0] RELOAD = BAUD_CNT_W'(CLKS_PER_BIT - 1);

  logic [BAUD_CNT_W-1:0] cnt_q;
  logic [BAUD_CNT_W-1:0] cnt_d;
  logic                  at_zero_s;

  assign at_zero_s = (cnt_q == 16'd0);

  // Next count: restart on load, otherwise count down and wrap to RELOAD
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (run) begin
      if (at_zero_s) begin
        cnt_d = RELOAD;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Boundary tick: last cycle of a bit period while a frame is active
  assign tick = run & at_zero_s;

  // Counter register with synchronous reset
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 8 data bits, LSB first, one start and one stop bit.
// Optional even parity bit between the last data bit and the stop bit when
// the macro UART_TX_PARITY_EN is defined (11-bit frame instead of 10).
// All outputs are registered; tx_out goes low on the first cycle after the
// accepting edge.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_done
);

  logic [STATE_W-1:0]   state_q,   state_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic                 tx_out_q,  tx_out_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q,  parity_d;
`endif

  logic accept_s;
  logic tick_s;
  logic run_s;

  // tx_ready_q is high exactly in IDLE, so it doubles as the IDLE qualifier
  assign accept_s = tx_valid & tx_ready_q;
  assign run_s    = (state_q != ST_IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk_in (clk_in),
    .reset  (reset),
    .load   (accept_s),
    .run    (run_s),
    .tick   (tick_s)
  );

  // Frame sequencing: state, shift register, data-bit index
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d   = ST_START;
          shift_d   = tx_data;
          bit_idx_d = FIRST_BIT_IDX;
`ifdef UART_TX_PARITY_EN
          parity_d  = even_parity(tx_data);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          state_d   = ST_DATA;
          bit_idx_d = FIRST_BIT_IDX;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          if (bit_idx_q == LAST_BIT_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            // Next data bit moves into shift[0]; index stops at 7
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          end
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick_s) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (tick_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        shift_d   = 8'd0;
        bit_idx_d = 3'd0;
      end
    endcase
  end

  // Output decode from the next state so the line level lands with the state
  always_comb begin
    tx_out_d   = IDLE_LEVEL;
    tx_ready_d = (state_d == ST_IDLE);
    tx_done_d  = (state_q == ST_STOP) & tick_s;
    case (state_d)
      ST_IDLE:   tx_out_d = IDLE_LEVEL;
      ST_START:  tx_out_d = START_LEVEL;
      ST_DATA:   tx_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_out_d = parity_d;
`endif
      ST_STOP:   tx_out_d = STOP_LEVEL;
      default:   tx_out_d = IDLE_LEVEL;
    endcase
  end

  // State and output registers; reset wins over everything including tx_valid
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'd0;
      bit_idx_q  <= 3'd0;
      tx_out_q   <= IDLE_LEVEL;
      tx_ready_q <= 1'b1;
      tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      tx_out_q   <= tx_out_d;
      tx_ready_q <= tx_ready_d;
      tx_done_q  <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx_out   = tx_out_q;
  assign tx_ready = tx_ready_q;
  assign tx_done  = tx_done_q;

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk_in cycles per serial bit (legal range 1..65535).
REQ-002 SHALL have port clk_in, input, 1: sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port tx_valid, input, 1: byte on tx_data is offered for transmission.
REQ-005 SHALL have port tx_data, input, 8: byte to transmit.
REQ-006 SHALL have port tx_ready, output, 1: high when a byte can be accepted.
REQ-007 SHALL have port tx_out, output, 1: serial line, idle high.
REQ-008 SHALL have port tx_done, output, 1: one-cycle pulse at frame completion.

Function
REQ-009 SHALL accept a byte on any rising edge where tx_valid and tx_ready are both high, latching tx_data into an internal shift register.
REQ-010 SHALL drive tx_ready high only in IDLE; tx_ready SHALL be low from the cycle after acceptance until frame end.
REQ-011 SHALL use FSM states IDLE, START, DATA, PARITY (macro only), STOP; IDLE->START on accept, START->DATA, DATA->PARITY or STOP after bit 7, PARITY->STOP, STOP->IDLE.
REQ-012 SHALL drive tx_out low in START, data bits LSB first in DATA, parity in PARITY, high in STOP and IDLE.
REQ-013 SHALL hold each of START, each DATA bit, PARITY and STOP for exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded at every bit boundary.
REQ-014 SHALL drive tx_out low on the first cycle after the accepting edge (latency 1).
REQ-015 SHALL track data bits with a 3-bit index that goes 0..7 and never wraps inside a frame.
REQ-016 SHALL pulse tx_done for exactly one cycle, on the first IDLE cycle after STOP, with tx_ready high in that same cycle.
REQ-017 SHALL let a byte offered during the tx_done cycle be accepted, so back-to-back frames have no idle gap beyond that one cycle.
REQ-018 SHALL ignore tx_valid and tx_data while not in IDLE; tx_data changes mid-frame SHALL NOT affect the frame.
REQ-019 SHALL, when CLKS_PER_BIT = 1, advance one bit per clock with no skipped or repeated bits.

Reset
REQ-020 SHALL, on reset high at a clock edge, force state IDLE, tx_out 1, tx_ready 1, tx_done 0, counters 0 and the shift register 0.
REQ-021 SHALL abandon any frame in progress when reset is asserted mid-frame, with tx_out high from the next edge; no tx_done pulse for that frame.
REQ-022 SHALL give reset priority over a simultaneous tx_valid.

Configuration
REQ-023 SHALL, with macro UART_TX_PARITY_EN defined, insert an even-parity bit (XOR of the 8 data bits) between bit 7 and STOP, giving an 11-bit frame.
REQ-024 SHALL, without UART_TX_PARITY_EN, omit the PARITY state entirely, giving a 10-bit frame; parity logic SHALL NOT be synthesised.

Structure
REQ-025 SHALL take its FSM state encodings and the frame constants (DATA_BITS = 8, idle level 1) from shared package uart_pkg, which the receiver also uses.
REQ-026 SHALL place the bit-period down-counter in sub-module uart_baud_tick, which emits a one-cycle bit-boundary tick and takes CLKS_PER_BIT as a parameter.

Verification
REQ-027 SHALL verify: CLKS_PER_BIT=4, send 0xA5 -> tx_out 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_done 1 cycle after 40 cycles.
REQ-028 SHALL verify: UART_TX_PARITY_EN, CLKS_PER_BIT=4, send 0x07 -> parity bit 1 before stop; 44-cycle frame.
REQ-029 SHALL verify: tx_valid held high with 0x55 then 0xAA -> second start bit begins the cycle after tx_done; both frames correct.
REQ-030 SHALL verify: reset asserted during data bit 3 of 0xFF -> tx_out 1 and tx_ready 1 the next cycle, no tx_done.
REQ-031 SHALL verify: CLKS_PER_BIT=1, send 0x00 -> tx_out low 9 consecutive cycles, then high 1 cycle.
REQ-032 SHALL verify: tx_data changed from 0x3C to 0xC3 mid-frame -> the serialised byte remains 0x3C.
